imu_spi_seq: RTL

//  Command sequencer that sits directly upstream of the SPI master and drives it.

---
 rtl/imu_spi_seq_if.sv | 22 ++
 rtl/imu_spi_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imu_spi_seq_if.sv
// SPI master command/response bus between the IMU sequencer and the SPI master.
// The sequencer drives commands; the SPI master returns done level and read data.
interface imu_spi_seq_if;
    logic        spi_write_en;
    logic [15:0] wt_data;
    logic        spi_done;
    logic [15:0] rd_data;

    modport master (
        output spi_write_en,
        output wt_data,
        input  spi_done,
        input  rd_data
    );

    modport slave (
        input  spi_write_en,
        input  wt_data,
        output spi_done,
        output rd_data
    );
endinterface

// File: rtl/imu_spi_seq.sv
// IMU command sequencer: power-up wait, four config writes, then a 10-byte burst
// read per data-ready interrupt, published as five {H,L} words with a vld strobe.
module imu_spi_seq #(
    parameter int PU_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INT,
    imu_spi_seq_if.master        spi,
    output logic                 init_done,
    output logic                 vld,
    output logic [15:0]          ptch_rt,
    output logic [15:0]          roll_rt,
    output logic [15:0]          yaw_rt,
    output logic [15:0]          ax,
    output logic [15:0]          ay
);
    typedef enum logic [3:0] {
        PWRUP     = 4'd0,
        CFG_PULSE = 4'd1,
        CFG_BLANK = 4'd2,
        CFG_WAIT  = 4'd3,
        IDLE      = 4'd4,
        RD_PULSE  = 4'd5,
        RD_BLANK  = 4'd6,
        RD_WAIT   = 4'd7,
        DONE      = 4'd8
    } state_t;

    localparam logic [PU_CNT_W-1:0] PU_MAX = {PU_CNT_W{1'b1}};
    localparam logic [PU_CNT_W-1:0] PU_ONE = {{(PU_CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h0D02;
            4'd1:    w = 16'h1062;
            4'd2:    w = 16'h1162;
            4'd3:    w = 16'h1460;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Read command: bit15 set, address 0x22 + idx, don't-care low byte zeroed.
    function automatic logic [15:0] rd_word(input logic [3:0] idx);
        return {8'hA2 + {4'h0, idx}, 8'h00};
    endfunction

    state_t               state_r, state_s;
    logic [PU_CNT_W-1:0]  pu_cnt_r, pu_cnt_s;
    logic [3:0]           idx_r, idx_s;
    logic                 pend_r, pend_s;
    logic                 en_r, en_s;
    logic [15:0]          wt_r, wt_s;
    logic                 init_r, init_s;
    logic                 vld_r, vld_s;
    logic                 cap_s, load_s;
    logic                 int_s1_r, int_s2_r, int_s3_r;
    logic                 rise_s;
    logic [7:0]           byte_r [10];
    logic [15:0]          ptch_r, roll_r, yaw_r, ax_r, ay_r;
    logic                 rd_hi_unused_s;

    assign rise_s         = int_s2_r & ~int_s3_r;
    assign rd_hi_unused_s = ^spi.rd_data[15:8];

    // INT synchronizer plus edge-detect flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1_r <= 1'b0;
            int_s2_r <= 1'b0;
            int_s3_r <= 1'b0;
        end else begin
            int_s1_r <= INT;
            int_s2_r <= int_s1_r;
            int_s3_r <= int_s2_r;
        end
    end

    // State and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= PWRUP;
            pu_cnt_r <= {PU_CNT_W{1'b0}};
            idx_r    <= 4'd0;
            pend_r   <= 1'b0;
            en_r     <= 1'b0;
            wt_r     <= 16'h0000;
            init_r   <= 1'b0;
            vld_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            pu_cnt_r <= pu_cnt_s;
            idx_r    <= idx_s;
            pend_r   <= pend_s;
            en_r     <= en_s;
            wt_r     <= wt_s;
            init_r   <= init_s;
            vld_r    <= vld_s;
        end
    end

    // Next-state logic; a pulse is scheduled on the same edge that enters *_PULSE.
    always_comb begin
        state_s  = state_r;
        pu_cnt_s = pu_cnt_r;
        idx_s    = idx_r;
        en_s     = 1'b0;
        wt_s     = wt_r;
        init_s   = init_r;
        vld_s    = 1'b0;
        cap_s    = 1'b0;
        load_s   = 1'b0;
        if (rise_s && (state_r != PWRUP) && (state_r != IDLE)) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end
        case (state_r)
            PWRUP: begin
                pu_cnt_s = pu_cnt_r + PU_ONE;
                if (pu_cnt_r == PU_MAX) begin
                    state_s = CFG_PULSE;
                    idx_s   = 4'd0;
                    en_s    = 1'b1;
                    wt_s    = cfg_word(4'd0);
                end else begin
                    state_s = PWRUP;
                end
            end
            CFG_PULSE: state_s = CFG_BLANK;
            CFG_BLANK: state_s = CFG_WAIT;
            CFG_WAIT: begin
                if (!spi.spi_done) begin
                    state_s = CFG_WAIT;
                end else if (idx_r == 4'd3) begin
                    init_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    idx_s   = idx_r + 4'd1;
                    en_s    = 1'b1;
                    wt_s    = cfg_word(idx_r + 4'd1);
                    state_s = CFG_PULSE;
                end
            end
            IDLE: begin
                if (rise_s || pend_r) begin
                    pend_s  = 1'b0;
                    idx_s   = 4'd0;
                    en_s    = 1'b1;
                    wt_s    = rd_word(4'd0);
                    state_s = RD_PULSE;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_PULSE: state_s = RD_BLANK;
            RD_BLANK: state_s = RD_WAIT;
            RD_WAIT: begin
                if (!spi.spi_done) begin
                    state_s = RD_WAIT;
                end else begin
                    cap_s = 1'b1;
                    if (idx_r == 4'd9) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        en_s    = 1'b1;
                        wt_s    = rd_word(idx_r + 4'd1);
                        state_s = RD_PULSE;
                    end
                end
            end
            DONE: begin
                load_s  = 1'b1;
                vld_s   = 1'b1;
                state_s = IDLE;
            end
            default: state_s = PWRUP;
        endcase
    end

    // Staging buffer so partially read samples never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) begin
                byte_r[i] <= 8'h00;
            end
        end else if (cap_s) begin
            byte_r[idx_r] <= spi.rd_data[7:0];
        end
    end

    // Published sample, updated together with the vld strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_r <= 16'h0000;
            roll_r <= 16'h0000;
            yaw_r  <= 16'h0000;
            ax_r   <= 16'h0000;
            ay_r   <= 16'h0000;
        end else if (load_s) begin
            ptch_r <= {byte_r[1], byte_r[0]};
            roll_r <= {byte_r[3], byte_r[2]};
            yaw_r  <= {byte_r[5], byte_r[4]};
            ax_r   <= {byte_r[7], byte_r[6]};
            ay_r   <= {byte_r[9], byte_r[8]};
        end
    end

    assign spi.spi_write_en = en_r;
    assign spi.wt_data      = wt_r;
    assign init_done        = init_r;
    assign vld              = vld_r;
    assign ptch_rt          = ptch_r;
    assign roll_rt          = roll_r;
    assign yaw_rt           = yaw_r;
    assign ax               = ax_r;
    assign ay               = ay_r;
endmodule
